insn_coverage_scheduler: RTL and testbench

INSN_COVERAGE_SCHEDULER -- requirements
Module: insn_coverage_scheduler

---
 rtl/insn_coverage_scheduler.sv | 146 ++++++++++++++
 tb/tb_insn_coverage_scheduler.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/insn_coverage_scheduler.sv
// Instruction coverage scheduler: stages one instruction word at a time for an
// external combinational decoder, folds the decoder's match vector into a sticky
// coverage map and keeps instruction / unknown-instruction counts for each run.
module insn_coverage_scheduler #(
  parameter int unsigned COV_LEN   = 37,
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned MAX_INSNS = 1000
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               stop,
  input  logic               clear,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        in_insn,
  output logic [31:0]        dec_insn,
  input  logic [COV_LEN-1:0] dec_vec,
  output logic [COV_LEN-1:0] cov_map,
  output logic [7:0]         cov_count,
  output logic [CNT_W-1:0]   insn_count,
  output logic [CNT_W-1:0]   unknown_count,
  output logic               multi_err,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  state_e             state_q;
  logic               busy_q;
  logic               done_q;
  logic               stage_full_q;
  logic [31:0]        dec_insn_q;
  logic [COV_LEN-1:0] cov_map_q;
  logic [7:0]         cov_count_q;
  logic [CNT_W-1:0]   insn_cnt_q;
  logic [CNT_W-1:0]   unk_cnt_q;
  logic               multi_q;

  logic [COV_LEN-1:0] cov_map_d;
  logic [CNT_W-1:0]   insn_cnt_d;
  logic [CNT_W-1:0]   unk_cnt_d;
  logic               multi_d;
  logic               complete_d;
  logic [7:0]         cov_count_d;

  // Result values that an evaluation of the staged word would produce
  always_comb begin
    cov_map_d   = cov_map_q | dec_vec;
    insn_cnt_d  = (insn_cnt_q == '1) ? insn_cnt_q : insn_cnt_q + 1'b1;
    unk_cnt_d   = ((dec_vec == '0) && (unk_cnt_q != '1)) ? unk_cnt_q + 1'b1 : unk_cnt_q;
    multi_d     = multi_q | (|(dec_vec & (dec_vec - 1'b1)));
    complete_d  = (cov_map_d == '1) || (32'(insn_cnt_d) == MAX_INSNS);
  end

  // Population count of the current coverage map, registered next edge
  always_comb begin
    cov_count_d = '0;
    for (int unsigned i = 0; i < COV_LEN; i++) begin
      cov_count_d = cov_count_d + 8'(cov_map_q[i]);
    end
  end

  // Control FSM together with the stage register and result registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      stage_full_q <= 1'b0;
      dec_insn_q   <= '0;
      cov_map_q    <= '0;
      cov_count_q  <= '0;
      insn_cnt_q   <= '0;
      unk_cnt_q    <= '0;
      multi_q      <= 1'b0;
    end else if (clear) begin
      state_q      <= S_IDLE;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      stage_full_q <= 1'b0;
      dec_insn_q   <= '0;
      cov_map_q    <= '0;
      cov_count_q  <= '0;
      insn_cnt_q   <= '0;
      unk_cnt_q    <= '0;
      multi_q      <= 1'b0;
    end else begin
      cov_count_q <= cov_count_d;
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q    <= S_RUN;
            busy_q     <= 1'b1;
            cov_map_q  <= '0;
            insn_cnt_q <= '0;
            unk_cnt_q  <= '0;
            multi_q    <= 1'b0;
          end
        end
        S_RUN: begin
          // A staged word is always evaluated, even on the cycle stop ends the run
          if (stage_full_q) begin
            cov_map_q    <= cov_map_d;
            insn_cnt_q   <= insn_cnt_d;
            unk_cnt_q    <= unk_cnt_d;
            multi_q      <= multi_d;
            stage_full_q <= 1'b0;
          end else if (in_valid && in_ready) begin
            dec_insn_q   <= in_insn;
            stage_full_q <= 1'b1;
          end
          if (stop || (stage_full_q && complete_d)) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_DONE;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready      = (state_q == S_RUN) && !stage_full_q && !stop && !clear;
  assign dec_insn      = dec_insn_q;
  assign cov_map       = cov_map_q;
  assign cov_count     = cov_count_q;
  assign insn_count    = insn_cnt_q;
  assign unknown_count = unk_cnt_q;
  assign multi_err     = multi_q;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule

// File: tb/tb_insn_coverage_scheduler.sv
// Testbench for insn_coverage_scheduler: a table of hand-derived vectors,
// directed multi-cycle sequences, and randomized traffic compared against a
// transaction-level reference model. The external decoder is modelled as
// dec_vec = dec_insn[3:0].
module tb_insn_coverage_scheduler;

  localparam int MAXI = 5;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0, stop = 1'b0, clear = 1'b0, in_valid = 1'b0;
  logic [31:0] in_insn = '0;
  logic        in_ready;
  logic [31:0] dec_insn;
  logic [3:0]  dec_vec, cov_map;
  logic [7:0]  cov_count;
  logic [15:0] insn_count, unknown_count;
  logic        multi_err, busy, done;

  logic        s_start = 1'b0, s_stop = 1'b0, s_clear = 1'b0, s_valid = 1'b0;
  logic [31:0] s_insn = '0;
  logic        s_ready;
  logic [31:0] s_dec_insn;
  logic [3:0]  s_dec_vec, s_cov_map;
  logic [7:0]  s_cov_count;
  logic [1:0]  s_insn_count, s_unknown_count;
  logic        s_multi_err, s_busy, s_done;

  assign dec_vec   = dec_insn[3:0];
  assign s_dec_vec = s_dec_insn[3:0];

  insn_coverage_scheduler #(.COV_LEN(4), .CNT_W(16), .MAX_INSNS(MAXI)) dut (
    .clock(clock), .reset(reset), .start(start), .stop(stop), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_insn(in_insn),
    .dec_insn(dec_insn), .dec_vec(dec_vec), .cov_map(cov_map),
    .cov_count(cov_count), .insn_count(insn_count), .unknown_count(unknown_count),
    .multi_err(multi_err), .busy(busy), .done(done)
  );

  insn_coverage_scheduler #(.COV_LEN(4), .CNT_W(2), .MAX_INSNS(1000)) dut_s (
    .clock(clock), .reset(reset), .start(s_start), .stop(s_stop), .clear(s_clear),
    .in_valid(s_valid), .in_ready(s_ready), .in_insn(s_insn),
    .dec_insn(s_dec_insn), .dec_vec(s_dec_vec), .cov_map(s_cov_map),
    .cov_count(s_cov_count), .insn_count(s_insn_count), .unknown_count(s_unknown_count),
    .multi_err(s_multi_err), .busy(s_busy), .done(s_done)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a run is either not started, running or finished; at most
  // one word waits for the decoder and is scored one cycle after acceptance.
  bit          m_run, m_fin, m_staged, m_multi;
  logic [31:0] m_dec;
  logic [3:0]  m_cov;
  int          m_ins, m_unk, m_cc;

  function automatic void model_reset();
    m_run = 0; m_fin = 0; m_staged = 0; m_multi = 0;
    m_dec = '0; m_cov = '0; m_ins = 0; m_unk = 0; m_cc = 0;
  endfunction

  function automatic bit model_ready(bit sp, bit cl);
    return m_run && !m_staged && !sp && !cl;
  endfunction

  function automatic void model_step(bit st, bit sp, bit cl, bit v, logic [31:0] w);
    int  prev_pop;
    bit  rdy;
    bit  fin;
    logic [3:0] vec;
    prev_pop = $countones(m_cov);
    rdy      = model_ready(sp, cl);
    if (cl) begin
      model_reset();
      return;
    end
    m_cc = prev_pop;
    if (m_run) begin
      fin = sp;
      if (m_staged) begin
        vec      = m_dec[3:0];
        m_cov    = m_cov | vec;
        m_ins    = (m_ins < 65535) ? m_ins + 1 : m_ins;
        if (vec == 4'd0) m_unk = (m_unk < 65535) ? m_unk + 1 : m_unk;
        if ($countones(vec) >= 2) m_multi = 1;
        m_staged = 0;
        if (m_cov == 4'hF || m_ins == MAXI) fin = 1;
      end else if (v && rdy) begin
        m_staged = 1;
        m_dec    = w;
      end
      if (fin) begin
        m_run = 0;
        m_fin = 1;
      end
    end else if (!m_fin && st) begin
      m_run = 1; m_cov = '0; m_ins = 0; m_unk = 0; m_multi = 0;
    end
  endfunction

  task automatic chk_outputs();
    chk("busy",          64'(busy),          64'(m_run));
    chk("done",          64'(done),          64'(m_fin));
    chk("cov_map",       64'(cov_map),       64'(m_cov));
    chk("cov_count",     64'(cov_count),     64'(m_cc));
    chk("insn_count",    64'(insn_count),    64'(m_ins));
    chk("unknown_count", 64'(unknown_count), 64'(m_unk));
    chk("multi_err",     64'(multi_err),     64'(m_multi));
    chk("dec_insn",      64'(dec_insn),      64'(m_dec));
  endtask

  logic last_ready;

  task automatic drive(input bit st, input bit sp, input bit cl, input bit v, input logic [31:0] w);
    start = st; stop = sp; clear = cl; in_valid = v; in_insn = w;
  endtask

  // One clock cycle with the current inputs, checked before and after the edge
  task automatic tick();
    #1;
    last_ready = in_ready;
    chk("in_ready", 64'(in_ready), 64'(model_ready(stop, clear)));
    @(posedge clock);
    model_step(start, stop, clear, in_valid, in_insn);
    #1;
    chk_outputs();
  endtask

  typedef struct {
    int          st, sp, cl, v;
    logic [31:0] w;
    int          rdy, ic, cc, unk, multi, bsy, dn, cov;
  } vec_t;

  vec_t tbl[15];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, errors %0d", errors);
    $fatal(1);
  end

  initial begin
    //          st sp cl v  word           rdy ic cc unk mul bsy dn cov
    tbl[0]  = '{1, 0, 0, 0, 32'h0,         0,  0, 0, 0,  0,  1,  0, 0};
    tbl[1]  = '{0, 0, 0, 1, 32'h1,         1,  0, 0, 0,  0,  1,  0, 0};
    tbl[2]  = '{0, 0, 0, 1, 32'h2,         0,  1, 0, 0,  0,  1,  0, 1};
    tbl[3]  = '{0, 0, 0, 1, 32'h2,         1,  1, 1, 0,  0,  1,  0, 1};
    tbl[4]  = '{0, 0, 0, 1, 32'h4,         0,  2, 1, 0,  0,  1,  0, 3};
    tbl[5]  = '{0, 0, 0, 1, 32'h4,         1,  2, 2, 0,  0,  1,  0, 3};
    tbl[6]  = '{0, 0, 0, 0, 32'h0,         0,  3, 2, 0,  0,  1,  0, 7};
    tbl[7]  = '{0, 0, 0, 0, 32'h0,         1,  3, 3, 0,  0,  1,  0, 7};
    tbl[8]  = '{0, 0, 0, 1, 32'hABCD0000,  1,  3, 3, 0,  0,  1,  0, 7};
    tbl[9]  = '{0, 0, 0, 0, 32'h0,         0,  4, 3, 1,  0,  1,  0, 7};
    tbl[10] = '{0, 0, 0, 1, 32'h5,         1,  4, 3, 1,  0,  1,  0, 7};
    tbl[11] = '{0, 0, 0, 0, 32'h0,         0,  5, 3, 1,  1,  0,  1, 7};
    tbl[12] = '{0, 0, 0, 1, 32'h8,         0,  5, 3, 1,  1,  0,  1, 7};
    tbl[13] = '{1, 0, 0, 0, 32'h0,         0,  5, 3, 1,  1,  0,  1, 7};
    tbl[14] = '{0, 0, 1, 0, 32'h0,         0,  0, 0, 0,  0,  0,  0, 0};

    // Reset values, checked while reset is still asserted
    model_reset();
    #2;
    chk("rst_in_ready", 64'(in_ready), 64'(0));
    chk_outputs();
    @(posedge clock);
    #1;
    reset = 1'b0;
    tick();

    // Table-driven run: distinct single-bit classes, an unknown word, a
    // two-bit match and completion on the instruction budget
    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].st != 0, tbl[i].sp != 0, tbl[i].cl != 0, tbl[i].v != 0, tbl[i].w);
      tick();
      chk($sformatf("tbl%0d_ready", i), 64'(last_ready),    64'(tbl[i].rdy));
      chk($sformatf("tbl%0d_ic", i),    64'(insn_count),    64'(tbl[i].ic));
      chk($sformatf("tbl%0d_cc", i),    64'(cov_count),     64'(tbl[i].cc));
      chk($sformatf("tbl%0d_unk", i),   64'(unknown_count), 64'(tbl[i].unk));
      chk($sformatf("tbl%0d_multi", i), 64'(multi_err),     64'(tbl[i].multi));
      chk($sformatf("tbl%0d_busy", i),  64'(busy),          64'(tbl[i].bsy));
      chk($sformatf("tbl%0d_done", i),  64'(done),          64'(tbl[i].dn));
      chk($sformatf("tbl%0d_cov", i),   64'(cov_map),       64'(tbl[i].cov));
    end

    // Full coverage of all four classes ends the run after the 4th evaluation
    drive(1, 0, 0, 0, 32'h0); tick();
    for (int k = 0; k < 4; k++) begin
      drive(0, 0, 0, 1, 32'(1) << k); tick();
      chk("cov_accept_ready", 64'(last_ready), 64'(1));
      tick();
      chk("cov_eval_ready", 64'(last_ready), 64'(0));
      chk("cov_done_edge", 64'(done), 64'(k == 3));
    end
    chk("cov_full_map", 64'(cov_map), 64'(4'hF));
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("cov_after_ready", 64'(last_ready), 64'(0));
    end
    chk("cov_after_count", 64'(cov_count), 64'(4));
    drive(0, 0, 1, 0, 32'h0); tick();

    // Instruction budget with identical words
    drive(1, 0, 0, 0, 32'h0); tick();
    drive(0, 0, 0, 1, 32'h2);
    for (int k = 0; k < 5; k++) begin
      tick();
      tick();
      chk("budget_done_edge", 64'(done), 64'(k == 4));
    end
    chk("budget_ic", 64'(insn_count), 64'(5));
    chk("budget_cc", 64'(cov_count), 64'(1));
    drive(0, 0, 1, 0, 32'h0); tick();

    // Stop alone with a staged word: the word is still scored
    drive(1, 0, 0, 0, 32'h0); tick();
    drive(0, 0, 0, 1, 32'h6); tick();
    drive(0, 1, 0, 0, 32'h0); tick();
    chk("stop_done", 64'(done), 64'(1));
    chk("stop_ic", 64'(insn_count), 64'(1));
    chk("stop_multi", 64'(multi_err), 64'(1));
    drive(0, 0, 1, 0, 32'h0); tick();

    // Stop and clear together with a staged word
    drive(1, 0, 0, 0, 32'h0); tick();
    drive(0, 0, 0, 1, 32'h3); tick();
    drive(0, 1, 1, 0, 32'h0); tick();
    chk("stopclr_busy", 64'(busy), 64'(0));
    chk("stopclr_done", 64'(done), 64'(0));
    chk("stopclr_ic", 64'(insn_count), 64'(0));
    chk("stopclr_cov", 64'(cov_map), 64'(0));
    chk("stopclr_dec", 64'(dec_insn), 64'(0));
    drive(0, 0, 0, 0, 32'h0); tick();

    // Asynchronous reset pulsed mid-cycle with a word staged
    drive(1, 0, 0, 0, 32'h0); tick();
    drive(0, 0, 0, 1, 32'h1); tick();
    drive(0, 0, 0, 1, 32'h1); tick();
    drive(0, 0, 0, 1, 32'h2); tick();
    drive(0, 0, 0, 0, 32'h0);
    #3;
    reset = 1'b1;
    #1;
    model_reset();
    chk("arst_ready", 64'(in_ready), 64'(0));
    chk_outputs();
    #1;
    reset = 1'b0;
    drive(1, 0, 0, 0, 32'h0); tick();
    tick();
    chk("arst_discard_ic", 64'(insn_count), 64'(0));
    drive(0, 0, 1, 0, 32'h0); tick();

    // Randomized traffic against the reference model
    for (int n = 0; n < 1500; n++) begin
      logic [31:0] w;
      w = $urandom;
      if ($urandom_range(0, 1) == 1) w[3:0] = 4'(1 << $urandom_range(0, 3));
      drive($urandom_range(0, 7) == 0, $urandom_range(0, 31) == 0,
            ($urandom_range(0, 63) == 0) || (m_fin && $urandom_range(0, 3) == 0),
            $urandom_range(0, 3) != 0, w);
      tick();
    end
    drive(0, 0, 1, 0, 32'h0); tick();
    drive(0, 0, 0, 0, 32'h0);

    // Counter saturation on a 2-bit counter instance
    s_start = 1'b1;
    @(posedge clock); #1;
    s_start = 1'b0;
    s_valid = 1'b1; s_insn = 32'h0;
    repeat (10) @(posedge clock);
    #1;
    s_valid = 1'b0;
    chk("sat_ic", 64'(s_insn_count), 64'(3));
    chk("sat_unk", 64'(s_unknown_count), 64'(3));
    chk("sat_busy", 64'(s_busy), 64'(1));
    s_valid = 1'b1; s_insn = 32'h3;
    @(posedge clock); #1;
    s_valid = 1'b0;
    @(posedge clock); #1;
    chk("sat_multi", 64'(s_multi_err), 64'(1));
    chk("sat_cov", 64'(s_cov_map), 64'(3));
    chk("sat_ic_hold", 64'(s_insn_count), 64'(3));
    chk("sat_unk_hold", 64'(s_unknown_count), 64'(3));
    s_stop = 1'b1;
    @(posedge clock); #1;
    s_stop = 1'b0;
    chk("sat_done", 64'(s_done), 64'(1));
    chk("sat_busy_off", 64'(s_busy), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
